// File: rtl/spi_cfg_pkg.sv
// spi_cfg_pkg: shared constants and FSM encoding
// for the SPI configuration write sequencer.
package spi_cfg_pkg;

  localparam logic [6:0] REG_EN_OUT_LO = 7'h00;
  localparam logic [6:0] REG_EN_OUT_HI = 7'h01;
  localparam logic [6:0] REG_EN_PWM_LO = 7'h02;
  localparam logic [6:0] REG_EN_PWM_HI = 7'h03;
  localparam logic [6:0] REG_PWM_DUTY  = 7'h04;

  localparam int   FRAME_BITS = 16;
  localparam logic WRITE_BIT  = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_t;

endpackage

// File: rtl/spi_cmd_fifo.sv
// spi_cmd_fifo: synchronous command queue with
// registered level, full and empty flags.
module spi_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 15,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [LW-1:0]    o_level,
  output logic [LW-1:0]    o_level_nxt
);

  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [LW-1:0]    r_level;
  logic             r_full;
  logic             r_empty;
  logic             w_push;
  logic             w_pop;
  logic [LW-1:0]    w_level_nxt;

  assign w_push = i_push & ~r_full;
  assign w_pop  = i_pop & ~r_empty;

  always_comb begin
    w_level_nxt = r_level;
    if (w_push && !w_pop) begin
      w_level_nxt = r_level + LVL_ONE;
    end else if (w_pop && !w_push) begin
      w_level_nxt = r_level - LVL_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == FULL_LVL);
      r_empty <= (w_level_nxt == '0);
    end
  end

  assign o_rdata     = r_mem[r_rptr];
  assign o_full      = r_full;
  assign o_empty     = r_empty;
  assign o_level     = r_level;
  assign o_level_nxt = w_level_nxt;

endmodule

// File: rtl/spi_cfg_master.sv
// spi_cfg_master: queued register writes serialised
// as 16-bit mode-0 SPI frames.
module spi_cfg_master
  import spi_cfg_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CS_SETUP   = 2,
  parameter int CS_HOLD    = 2,
  parameter int GAP_CYCLES = 4,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [6:0]    cmd_addr,
  input  logic [7:0]    cmd_data,
  output logic          SCLK,
  output logic          nCS,
  output logic          COPI,
  output logic          busy,
  output logic          frame_done,
  output logic [LW-1:0] fifo_level
);

  if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_bad_div
    $error("CLK_DIV must be 2..255");
  end
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two, 2..16");
  end
  if (CS_SETUP < 1 || CS_HOLD < 1 || GAP_CYCLES < 1) begin : g_bad_cs
    $error("CS_SETUP, CS_HOLD and GAP_CYCLES must be >= 1");
  end

  localparam int CW = 16;
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] SETUP_END = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] DIV_END   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HOLD_END  = CW'(CS_HOLD - 1);
  localparam logic [CW-1:0] GAP_END   = CW'(GAP_CYCLES - 1);
  localparam logic [3:0]    LAST_BIT  = 4'(FRAME_BITS - 1);

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]    r_bit, w_bit_nxt;
  logic [14:0]   r_shift, w_shift_nxt;
  logic          r_sclk, w_sclk_nxt;
  logic          r_ncs, w_ncs_nxt;
  logic          r_copi, w_copi_nxt;
  logic          r_done, w_done_nxt;
  logic          r_busy, w_busy_nxt;

  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic [14:0]   w_rdata;
  logic [LW-1:0] w_level;
  logic [LW-1:0] w_level_nxt;

  assign w_push = cmd_valid & ~w_full;

  spi_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (15)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_wdata     ({cmd_addr, cmd_data}),
    .o_rdata     (w_rdata),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_level     (w_level),
    .o_level_nxt (w_level_nxt)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CNT_ONE;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_sclk_nxt  = r_sclk;
    w_ncs_nxt   = r_ncs;
    w_copi_nxt  = r_copi;
    w_done_nxt  = 1'b0;
    w_pop       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_rdata;
          w_copi_nxt  = WRITE_BIT;
          w_ncs_nxt   = 1'b0;
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        if (r_cnt == SETUP_END) begin
          w_cnt_nxt   = '0;
          w_sclk_nxt  = 1'b1;
          w_bit_nxt   = '0;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (r_cnt == DIV_END) begin
          w_cnt_nxt  = '0;
          w_sclk_nxt = ~r_sclk;
          if (!r_sclk) begin
            w_bit_nxt = r_bit + 4'd1;
          end else if (r_bit == LAST_BIT) begin
            // last falling edge: no further rise follows
            w_copi_nxt  = 1'b0;
            w_state_nxt = S_HOLD;
          end else begin
            w_copi_nxt  = r_shift[14];
            w_shift_nxt = {r_shift[13:0], 1'b0};
          end
        end
      end
      S_HOLD: begin
        if (r_cnt == HOLD_END) begin
          w_cnt_nxt   = '0;
          w_ncs_nxt   = 1'b1;
          w_done_nxt  = 1'b1;
          w_state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (r_cnt == GAP_END) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE) | (w_level_nxt != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_sclk  <= 1'b0;
      r_ncs   <= 1'b1;
      r_copi  <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_sclk  <= w_sclk_nxt;
      r_ncs   <= w_ncs_nxt;
      r_copi  <= w_copi_nxt;
      r_done  <= w_done_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign cmd_ready  = ~w_full;
  assign SCLK       = r_sclk;
  assign nCS        = r_ncs;
  assign COPI       = r_copi;
  assign busy       = r_busy;
  assign frame_done = r_done;
  assign fifo_level = w_level;

endmodule

// File: tb/tb_spi_cfg_master.sv
// tb_spi_cfg_master: directed scoreboard bench with an
// SPI receiver model standing in for the peripheral.
module tb_spi_cfg_master;
  import spi_cfg_pkg::*;

  localparam int GAP  = 4;
  localparam int LOW0 = 2 + 32 * 4 + 2 - 4;
  localparam int LOW1 = 1 + 32 * 2 + 1 - 2;
  localparam int PER0 = 8;
  localparam int PER1 = 4;
  localparam int TMO  = 3000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sel = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [6:0] cmd_addr = '0;
  logic [7:0] cmd_data = '0;

  logic       v0, rdy0, sclk0, ncs0, copi0, busy0, done0;
  logic       v1, rdy1, sclk1, ncs1, copi1, busy1, done1;
  logic [2:0] lvl0, lvl1;
  logic       m_rdy, m_sclk, m_ncs, m_copi, m_busy, m_done;
  logic [2:0] m_lvl;

  int n_chk = 0;
  int n_err = 0;
  int n_done = 0;
  logic [15:0] sb_q[$];
  logic [7:0]  regs [5];
  logic [7:0]  snap [5];
  logic        saw_full = 1'b0;

  always #5 clk = ~clk;

  assign v0 = cmd_valid & ~sel;
  assign v1 = cmd_valid & sel;
  assign m_rdy  = sel ? rdy1  : rdy0;
  assign m_sclk = sel ? sclk1 : sclk0;
  assign m_ncs  = sel ? ncs1  : ncs0;
  assign m_copi = sel ? copi1 : copi0;
  assign m_busy = sel ? busy1 : busy0;
  assign m_done = sel ? done1 : done0;
  assign m_lvl  = sel ? lvl1  : lvl0;

  spi_cfg_master u0 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(v0), .cmd_ready(rdy0),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .SCLK(sclk0), .nCS(ncs0), .COPI(copi0),
    .busy(busy0), .frame_done(done0), .fifo_level(lvl0)
  );

  spi_cfg_master #(
    .CLK_DIV(2), .CS_SETUP(1), .CS_HOLD(1)
  ) u1 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(v1), .cmd_ready(rdy1),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .SCLK(sclk1), .nCS(ncs1), .COPI(copi1),
    .busy(busy1), .frame_done(done1), .fifo_level(lvl1)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // receiver: samples at negedge, sees COPI at each SCLK rise
  logic        p_sclk = 1'b0, p_ncs = 1'b1, p_copi = 1'b0;
  logic        idle_seen = 1'b1;
  logic [15:0] m_sh = '0;
  logic [15:0] exp_f;
  int m_bits = 0, m_low = 0, m_high = 0, cyc = 0, last_rise = 0;
  int idx;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_bits = 0; m_low = 0; m_high = 0;
      p_sclk = 1'b0; p_ncs = 1'b1; p_copi = 1'b0;
      idle_seen = 1'b1;
    end else begin
      if (!m_busy) idle_seen = 1'b1;
      if (m_done) n_done++;
      if (m_sclk && !p_sclk) begin
        chk("copi_stable", m_copi, p_copi);
        if (m_bits > 0)
          chk("sclk_period", cyc - last_rise, sel ? PER1 : PER0);
        last_rise = cyc;
        m_sh = {m_sh[14:0], m_copi};
        m_bits++;
      end
      if (!m_ncs && p_ncs) begin
        if (!idle_seen) chk("gap_len", m_high, GAP + 1);
        idle_seen = 1'b0;
        m_bits = 0;
        m_low = 0;
      end
      if (m_ncs && !p_ncs) begin
        chk("done_at_rise", m_done, 1);
        chk("bit_count", m_bits, 16);
        chk("ncs_low", m_low, sel ? LOW1 : LOW0);
        chk("sb_pending", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) begin
          exp_f = sb_q.pop_front();
          chk("frame", m_sh, exp_f);
        end
        idx = int'(m_sh[14:8]);
        if (idx < 5) regs[idx] = m_sh[7:0];
        m_high = 0;
      end
      if (!m_ncs) m_low++;
      else m_high++;
      p_sclk = m_sclk;
      p_ncs  = m_ncs;
      p_copi = m_copi;
    end
  end

  task automatic push(input logic [6:0] a, input logic [7:0] d);
    int t = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_data  = d;
    while (!m_rdy && t < TMO) begin
      if (!saw_full) begin
        chk("full_level", m_lvl, 3'd4);
        saw_full = 1'b1;
      end
      @(negedge clk);
      t++;
    end
    chk("push_ready", m_rdy, 1);
    @(posedge clk);
    sb_q.push_back({1'b1, a, d});
  endtask

  task automatic release_valid();
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    do begin
      @(negedge clk);
      #1;
      t++;
    end while (m_busy && t < TMO);
    chk("idle_reached", m_busy, 0);
    chk("sb_drained", sb_q.size(), 0);
  endtask

  initial begin
    int t, d0;
    for (int i = 0; i < 5; i++) regs[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sclk", sclk0, 0);
    chk("rst_ncs", ncs0, 1);
    chk("rst_copi", copi0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_level", lvl0, 0);
    chk("rst_ready", rdy0, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // single frame, busy release after gap
    d0 = n_done;
    push(REG_EN_OUT_LO, 8'hA5);
    release_valid();
    t = 0;
    do begin
      @(negedge clk);
      #1;
      t++;
    end while (!m_done && t < TMO);
    chk("t1_done_seen", m_done, 1);
    repeat (GAP - 1) @(negedge clk);
    #1;
    chk("t1_busy_in_gap", m_busy, 1);
    @(negedge clk);
    #1;
    chk("t1_busy_drop", m_busy, 0);
    chk("t1_frame", m_sh, 16'h80A5);
    chk("t1_one_done", n_done - d0, 1);

    // burst of six, FIFO fills and one beat stalls
    saw_full = 1'b0;
    push(7'h10, 8'h01);
    push(7'h21, 8'h12);
    push(7'h32, 8'h23);
    push(7'h43, 8'h34);
    push(7'h54, 8'h45);
    push(7'h65, 8'h56);
    release_valid();
    wait_idle();
    chk("t2_saw_full", saw_full, 1);

    // loopback register writes
    push(REG_PWM_DUTY, 8'h80);
    push(REG_EN_OUT_HI, 8'h3C);
    push(REG_EN_PWM_LO, 8'hFF);
    release_valid();
    wait_idle();
    chk("t3_pwm_duty", regs[4], 8'h80);
    chk("t3_en_out_hi", regs[1], 8'h3C);
    chk("t3_en_pwm_lo", regs[2], 8'hFF);

    // reset during bit 7 of a frame
    push(REG_EN_OUT_LO, 8'h11);
    push(REG_EN_OUT_HI, 8'h22);
    release_valid();
    t = 0;
    do begin
      @(negedge clk);
      #1;
      t++;
    end while (m_bits < 8 && t < TMO);
    chk("t4_reach_bit7", m_bits, 8);
    chk("t4_level_before", m_lvl, 1);
    @(posedge clk);
    #2;
    d0 = n_done;
    rst_n = 1'b0;
    #1;
    chk("t4_ncs", ncs0, 1);
    chk("t4_sclk", sclk0, 0);
    chk("t4_level", lvl0, 0);
    chk("t4_done", done0, 0);
    chk("t4_busy", busy0, 0);
    sb_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    #1;
    chk("t4_no_done", n_done, d0);
    chk("t4_ncs_idle", ncs0, 1);
    push(REG_EN_PWM_HI, 8'h5A);
    release_valid();
    wait_idle();
    chk("t4_clean_frame", m_sh, 16'h835A);
    chk("t4_reg", regs[3], 8'h5A);

    // out-of-range address passes through untouched
    for (int i = 0; i < 5; i++) snap[i] = regs[i];
    push(7'h7F, 8'h00);
    release_valid();
    wait_idle();
    chk("t5_frame", m_sh, 16'hFF00);
    for (int i = 0; i < 5; i++) chk("t5_regs_kept", regs[i], snap[i]);

    // fast instance
    @(negedge clk);
    sel = 1'b1;
    push(REG_PWM_DUTY, 8'h3C);
    push(REG_EN_OUT_LO, 8'hC3);
    release_valid();
    wait_idle();
    chk("t6_pwm_duty", regs[4], 8'h3C);
    chk("t6_en_out_lo", regs[0], 8'hC3);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
